// File: rtl/rr_arbiter_param.sv
// rr_arbiter_param: N-way round-robin arbiter with registered, held one-hot grants.
// Optional max-hold preemption is built when RRA_MAX_HOLD_EN is defined.

module rra_lane #(
  parameter int IDX = 0,
  parameter int IDW = 2
) (
  input  logic           req,
  input  logic           excl,
  input  logic [IDW-1:0] ptr,
  output logic           elig,
  output logic           hi
);
  localparam logic [IDW-1:0] IDX_V = IDW'(IDX);

  assign elig = req & ~excl;
  // Lanes at or above the pointer form the first search pass; the rest wrap.
  assign hi   = elig & (IDX_V >= ptr);
endmodule

module rr_arbiter_param #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 preempt
);
  localparam int IDW = $clog2(N);
  localparam logic [N-1:0] ONE = N'(1);

  if (N < 2 || N > 32) begin : g_bad_n
    $error("rr_arbiter_param: N must be in 2..32");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("rr_arbiter_param: MAX_HOLD must be >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic [IDW-1:0] ptr, ptr_inc, arb_ptr, win;
  logic [N-1:0]   elig_v, hi_v, win_oh;
  logic           found, owner_req, force_rel, revoke;

  function automatic logic [IDW-1:0] lsb_idx(input logic [N-1:0] v);
    lsb_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) lsb_idx = IDW'(i);
  endfunction

  // Wrap at N so non-power-of-two sizes never point at a missing requester.
  assign ptr_inc = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
  assign arb_ptr = (state == BUSY) ? ptr_inc : ptr;

  for (genvar i = 0; i < N; i++) begin : g_lane
    rra_lane #(.IDX(i), .IDW(IDW)) u_lane (
      .req  (req[i]),
      .excl (gnt[i]),
      .ptr  (arb_ptr),
      .elig (elig_v[i]),
      .hi   (hi_v[i])
    );
  end

  assign found     = |elig_v;
  assign win       = (|hi_v) ? lsb_idx(hi_v) : lsb_idx(elig_v);
  assign win_oh    = ONE << win;
  assign owner_req = |(req & gnt);

`ifdef RRA_MAX_HOLD_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  logic [HCW-1:0] hold_cnt;

  assign force_rel = (hold_cnt == HOLD_LAST) && (|(req & ~gnt));
`else
  assign force_rel = 1'b0;
`endif

  assign revoke = (state == BUSY) && owner_req && force_rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      preempt   <= 1'b0;
      ptr       <= '0;
`ifdef RRA_MAX_HOLD_EN
      hold_cnt  <= '0;
`endif
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt       <= win_oh;
            gnt_valid <= 1'b1;
            gnt_id    <= win;
            state     <= BUSY;
`ifdef RRA_MAX_HOLD_EN
            hold_cnt  <= '0;
`endif
          end
        end
        BUSY: begin
          if (!owner_req || revoke) begin
            ptr     <= ptr_inc;
            preempt <= revoke;
            if (found) begin
              gnt    <= win_oh;
              gnt_id <= win;
`ifdef RRA_MAX_HOLD_EN
              hold_cnt <= '0;
`endif
            end else begin
              gnt       <= '0;
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end
`ifdef RRA_MAX_HOLD_EN
          // Saturate so a lone owner can keep the grant indefinitely.
          else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_arbiter_param.sv
// Bench for rr_arbiter_param: directed scoreboard vectors, an N=3 wrap check,
// and a long random run checking one-hot grants and bounded waiting.

module tb_rr_arbiter_param;
  localparam int N = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req = '0, gnt;
  logic       gnt_valid, preempt;
  logic [1:0] gnt_id;
  logic [2:0] req3 = '0, gnt3;
  logic       gv3, pre3;
  logic [1:0] id3;

  rr_arbiter_param #(.N(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .preempt(preempt)
  );

  rr_arbiter_param #(.N(3), .MAX_HOLD(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .gnt(gnt3),
    .gnt_valid(gv3), .gnt_id(id3), .preempt(pre3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] id;
    logic       pre;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0, errors = 0;
  bit         rnd_on = 1'b0;
  logic [3:0] prev_gnt = '0;
  int         wait_cnt[4] = '{0, 0, 0, 0};

  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id,
                      input string tag, input logic pre = 1'b0);
    exp_t e;
    @(negedge clk);
    req = r;
    e.gnt = g; e.vld = |g; e.id = id; e.pre = pre; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic chk_now(input string tag, input logic [3:0] g, input logic v, input logic [1:0] id);
    checks++;
    if (gnt !== g || gnt_valid !== v || gnt_id !== id || preempt !== 1'b0) begin
      errors++;
      $display("FAIL %s: gnt=%b vld=%b id=%0d pre=%b, want gnt=%b vld=%b id=%0d pre=0",
               tag, gnt, gnt_valid, gnt_id, preempt, g, v, id);
    end
  endtask

  task automatic step3(input logic [2:0] r, input logic [2:0] g, input logic [1:0] id, input string tag);
    @(negedge clk);
    req3 = r;
    @(posedge clk);
    #2;
    checks++;
    if (gnt3 !== g || gv3 !== (|g) || id3 !== id || pre3 !== 1'b0) begin
      errors++;
      $display("FAIL %s: gnt=%b vld=%b id=%0d, want gnt=%b vld=%b id=%0d",
               tag, gnt3, gv3, id3, g, |g, id);
    end
  endtask

  // Scoreboard monitor: one expectation per cycle in which the driver pushed one.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt_valid !== e.vld || gnt_id !== e.id || preempt !== e.pre) begin
        errors++;
        $display("FAIL %s: gnt=%b vld=%b id=%0d pre=%b, want gnt=%b vld=%b id=%0d pre=%b",
                 e.tag, gnt, gnt_valid, gnt_id, preempt, e.gnt, e.vld, e.id, e.pre);
      end
    end
  end

  // Random-phase invariants and wait bound (grants to others while continuously requesting).
  always @(posedge clk) begin
    #1;
    if (rnd_on) begin
      checks++;
      if ($isunknown(gnt) || !(gnt == '0 || $onehot(gnt)) || gnt_valid !== (|gnt) ||
          (gnt != '0 && gnt[gnt_id] !== 1'b1)) begin
        errors++;
        $display("FAIL rnd_onehot: gnt=%b vld=%b id=%0d, want one-hot/zero gnt, vld=|gnt, gnt[id]=1",
                 gnt, gnt_valid, gnt_id);
      end
      if (gnt != '0 && gnt != prev_gnt) begin
        for (int i = 0; i < 4; i++) begin
          if (gnt[i] || !req[i]) wait_cnt[i] = 0;
          else begin
            wait_cnt[i]++;
            checks++;
            if (wait_cnt[i] > N - 1) begin
              errors++;
              $display("FAIL rnd_fair: requester %0d saw %0d grants to others, want <= %0d",
                       i, wait_cnt[i], N - 1);
            end
          end
        end
      end
    end
    prev_gnt = gnt;
  end

  initial begin
    logic [3:0] nr;
    #2;
    chk_now("reset_init", 4'b0000, 1'b0, 2'd0);
    #10 rst_n = 1'b1;

    // Reset asserted mid-grant clears outputs without a clock edge.
    step(4'b0100, 4'b0100, 2'd2, "t1_grant");
    step(4'b0100, 4'b0100, 2'd2, "t1_hold");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_now("t1_async_rst", 4'b0000, 1'b0, 2'd0);
    rst_n = 1'b1;
    step(4'b1111, 4'b0001, 2'd0, "t1_after_rst");

    // Rotation with each owner dropping for one cycle.
    step(4'b1110, 4'b0010, 2'd1, "t2_rot1");
    step(4'b1111, 4'b0010, 2'd1, "t2_hold1");
    step(4'b1101, 4'b0100, 2'd2, "t2_rot2");
    step(4'b1111, 4'b0100, 2'd2, "t2_hold2");
    step(4'b1011, 4'b1000, 2'd3, "t2_rot3");
    step(4'b1111, 4'b1000, 2'd3, "t2_hold3");
    step(4'b0111, 4'b0001, 2'd0, "t2_rot0");

    // Owner 2 releases -> ptr=3, req=0011 must wrap to 0.
    step(4'b0100, 4'b0100, 2'd2, "t3_to2");
    step(4'b0100, 4'b0100, 2'd2, "t3_hold2");
    step(4'b0011, 4'b0001, 2'd0, "t3_wrap");

    // Long hold under full contention.
    step(4'b0010, 4'b0010, 2'd1, "t4_to1");
    repeat (20) step(4'b1111, 4'b0010, 2'd1, "t4_hold");
    step(4'b1101, 4'b0100, 2'd2, "t4_rel");
    step(4'b0000, 4'b0000, 2'd2, "t4_idle");
    step(4'b0000, 4'b0000, 2'd2, "t4_idle_keep_id");

    // Sole requester re-requests and wins again.
    step(4'b0100, 4'b0100, 2'd2, "sole_regrant");
    step(4'b0000, 4'b0000, 2'd2, "sole_idle");

`ifdef RRA_MAX_HOLD_EN
    step(4'b0101, 4'b0001, 2'd0, "t5_own");
    repeat (7) step(4'b0101, 4'b0001, 2'd0, "t5_hold");
    step(4'b0101, 4'b0100, 2'd2, "t5_preempt", 1'b1);
    step(4'b0101, 4'b0100, 2'd2, "t5_pulse_end");
    step(4'b0000, 4'b0000, 2'd2, "t5_idle");
    step(4'b0001, 4'b0001, 2'd0, "t5_solo_grant");
    repeat (30) step(4'b0001, 4'b0001, 2'd0, "t5_solo_nopre");
    step(4'b0000, 4'b0000, 2'd0, "t5_end");
`else
    step(4'b0101, 4'b0001, 2'd0, "t5_own");
    repeat (30) step(4'b0101, 4'b0001, 2'd0, "t5_nopreempt");
    step(4'b0000, 4'b0000, 2'd0, "t5_end");
`endif
    repeat (2) @(negedge clk);

    // N=3: owner 2 releases from ptr=2, pointer wraps to 0.
    step3(3'b010, 3'b010, 2'd1, "n3_grant1");
    step3(3'b100, 3'b100, 2'd2, "n3_to2");
    step3(3'b011, 3'b001, 2'd0, "n3_wrap");
    step3(3'b110, 3'b010, 2'd1, "n3_next");
    step3(3'b000, 3'b000, 2'd1, "n3_idle");

    // Random requests: waiting requesters stay up, owners release at random.
    @(negedge clk);
    rnd_on = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      nr = req;
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(3) == 0) nr[i] = 1'b0;
        end else if (!req[i] && $urandom_range(2) == 0) begin
          nr[i] = 1'b1;
        end
      end
      req = nr;
    end
    @(negedge clk);
    rnd_on = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
